// File: rtl/div_seq_param.sv
// Radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional signed operation is enabled by defining DIV_SIGNED_EN (adds the signed_op port).
module div_seq_param #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
`ifdef DIV_SIGNED_EN
  input  logic          signed_op,
`endif
  output logic [DW-1:0] q,
  output logic [VW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          div_zero
);

  // Handshake: start is accepted on a rising edge only while busy==0; busy is high
  // from the cycle after accept through the done cycle; done pulses for one cycle and
  // q/r/div_zero are valid from that cycle until the next accepted start.

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef DIV_SIGNED_EN
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
`endif

  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic [VW+1:0] trial;
  logic          q_bit;
  logic [VW:0]   rem_nxt;
  logic [DW-1:0] quo_nxt;
  logic [DW-1:0] q_fin;
  logic [VW-1:0] r_fin;

  // Operand magnitudes; the unsigned build passes operands straight through.
  always_comb begin
    a_mag = a;
    b_mag = b;
`ifdef DIV_SIGNED_EN
    if (signed_op && a[DW-1]) a_mag = -a;
    if (signed_op && b[VW-1]) b_mag = -b;
`endif
  end

  // One restoring step; the trial is one bit wider so its sign is unambiguous.
  always_comb begin
    trial   = {rem_q, dvd_q[DW-1]} - {2'b00, dvs_q};
    q_bit   = ~trial[VW+1];
    rem_nxt = q_bit ? trial[VW:0] : {rem_q[VW-1:0], dvd_q[DW-1]};
    quo_nxt = {dvd_q[DW-2:0], q_bit};
    q_fin   = quo_nxt;
    r_fin   = rem_nxt[VW-1:0];
`ifdef DIV_SIGNED_EN
    if (qneg_q) q_fin = -quo_nxt;
    if (rneg_q) r_fin = -rem_nxt[VW-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = a_mag;
          dvs_d = b_mag;
          rem_d = '0;
          cnt_d = CW'(DW - 1);
`ifdef DIV_SIGNED_EN
          qneg_d = signed_op & (a[DW-1] ^ b[VW-1]);
          rneg_d = signed_op & a[DW-1];
`endif
          if (b == '0) begin
            // Divide by zero skips the iteration entirely.
            state_d = FIN;
            q_d     = '1;
            r_d     = a[VW-1:0];
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        dvd_d = quo_nxt;
        if (cnt_q == '0) begin
          state_d = FIN;
          q_d     = q_fin;
          r_d     = r_fin;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed bench for div_seq_param (DW=32, VW=16): arithmetic reference model checked
// every cycle, plus literal expectations per directed vector.
module tb_div_seq_param;

  localparam int DW = 32;
  localparam int VW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          signed_op;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          busy;
  logic          done;
  logic          div_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_seq_param #(.DW(DW), .VW(VW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef DIV_SIGNED_EN
    .signed_op(signed_op),
`endif
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic void ref_div(input logic [DW-1:0] ia, input logic [VW-1:0] ib,
                                  input logic is, output logic [DW-1:0] oq,
                                  output logic [VW-1:0] orr, output logic odz);
    longint sa, sb, qq, rr;
    if (ib == '0) begin
      oq  = '1;
      orr = ia[VW-1:0];
      odz = 1'b1;
    end else if (is) begin
      sa  = longint'($signed(ia));
      sb  = longint'($signed(ib));
      qq  = sa / sb;
      rr  = sa % sb;
      oq  = qq[DW-1:0];
      orr = rr[VW-1:0];
      odz = 1'b0;
    end else begin
      oq  = ia / {16'h0, ib};
      orr = VW'(ia % {16'h0, ib});
      odz = 1'b0;
    end
  endfunction

  // m_left: cycles of busy still to come including the current one (0 = idle).
  int            m_left;
  logic [DW-1:0] m_q, p_q;
  logic [VW-1:0] m_r, p_r;
  logic          m_dz, p_dz;

  initial begin
    m_left = 0;
    m_q = '0; m_r = '0; m_dz = 1'b0;
    p_q = '0; p_r = '0; p_dz = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_left = 0;
        m_q = '0; m_r = '0; m_dz = 1'b0;
      end else if (m_left == 0) begin
        if (start) begin
          ref_div(a, b, signed_op, p_q, p_r, p_dz);
          m_left = (b == '0) ? 1 : DW + 1;
        end
      end else begin
        m_left--;
      end
      if (m_left == 1) begin
        m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
      #1;
      total++;
      if ({busy, done, div_zero, q, r} !== {(m_left > 0), (m_left == 1), m_dz, m_q, m_r}) begin
        bad++;
        $display("FAIL cycle_cmp cyc=%0d busy/done/dz/q/r act=%0b/%0b/%0b/%h/%h exp=%0b/%0b/%0b/%h/%h",
                 cyc, busy, done, div_zero, q, r, (m_left > 0), (m_left == 1), m_dz, m_q, m_r);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE; returns the cycle (1 = first cycle after accept) done is seen.
  task automatic do_op(input logic [DW-1:0] ta, input logic [VW-1:0] tbv, input logic ts,
                       input int mid_at, output int lat);
    @(negedge clk);
    a = ta; b = tbv; signed_op = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = VW'($urandom_range(0, 65535));
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == mid_at) begin
        start = 1'b1; a = 32'd1000; b = 16'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout act=no_done exp=done_within_100");
    end
  endtask

  task automatic run_case(input string name, input logic [DW-1:0] ta, input logic [VW-1:0] tbv,
                          input logic ts, input int mid_at, input int exp_lat,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
    int lat;
    do_op(ta, tbv, ts, mid_at, lat);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_q"},   64'(q), 64'(eq));
    check({name, "_r"},   64'(r), 64'(er));
    check({name, "_dz"},  64'(div_zero), 64'(edz));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; signed_op = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_qr",   64'({q, r, div_zero}), 64'd0);
    reset = 1'b0;

    run_case("t2_16_4",  32'd16, 16'd4, 1'b0, 0,  33, 32'd4, 16'd0, 1'b0);
    run_case("t3_18_5",  32'd18, 16'd5, 1'b0, 10, 33, 32'd3, 16'd3, 1'b0);

    // Reset in the middle of an operation clears outputs immediately.
    @(negedge clk);
    a = 32'd100; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_done", 64'(done), 64'd0);
    check("t1_q",    64'(q), 64'd0);
    check("t1_r",    64'(r), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_case("t1_after", 32'd200, 16'd9, 1'b0, 0, 33, 32'd22, 16'd2, 1'b0);

    run_case("t4_big",   32'hffffffee, 16'd5,     1'b0, 0, 33, 32'h3333332f, 16'd3,      1'b0);
    run_case("u_a_lt_b", 32'd18,       16'hfffb,  1'b0, 0, 33, 32'd0,        16'd18,     1'b0);
    run_case("u_maxdiv", 32'hffffffff, 16'hffff,  1'b0, 0, 33, 32'h00010001, 16'd0,      1'b0);
    run_case("u_pow2",   32'h12345678, 16'h8000,  1'b0, 0, 33, 32'h00002468, 16'h5678,   1'b0);
    run_case("t6_dz",    32'd7,        16'd0,     1'b0, 0, 1,  32'hffffffff, 16'd7,      1'b1);
    run_case("post_dz",  32'd1,        16'd1,     1'b0, 0, 33, 32'd1,        16'd0,      1'b0);
`ifdef DIV_SIGNED_EN
    run_case("s_neg_a",  32'hffffffee, 16'd5,     1'b1, 0, 33, 32'hfffffffd, 16'hfffd,   1'b0);
    run_case("s_neg_b",  32'd18,       16'hfffb,  1'b1, 0, 33, 32'hfffffffd, 16'd3,      1'b0);
    run_case("s_ovf",    32'h80000000, 16'hffff,  1'b1, 0, 33, 32'h80000000, 16'd0,      1'b0);
    run_case("s_dz",     32'hfffffffb, 16'd0,     1'b1, 0, 1,  32'hffffffff, 16'hfffb,   1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
